// File: rtl/pool_pkg.sv
// Shared constants, FSM state type and frame-size helpers for the pooling
// result serializer.
package pool_pkg;

  localparam int DW = 16;
  localparam int CW = 8;

  localparam int POOL_SHIFT_2X2 = 1;
  localparam int POOL_SHIFT_4X4 = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  // Pooled outputs per frame: (rows >> k) * (cols >> k); max 15*15 fits in CW bits.
  function automatic logic [CW-1:0] frame_words(input logic [4:0] s1,
                                                input logic [4:0] s2,
                                                input logic       sel);
    logic [4:0] r;
    logic [4:0] c;
    logic [9:0] p;
    r = sel ? (s1 >> POOL_SHIFT_4X4) : (s1 >> POOL_SHIFT_2X2);
    c = sel ? (s2 >> POOL_SHIFT_4X4) : (s2 >> POOL_SHIFT_2X2);
    p = 10'(r) * 10'(c);
    return p[CW-1:0];
  endfunction

  function automatic logic [CW-1:0] frame_groups(input logic [CW-1:0] n);
    logic [CW:0] t;
    t = {1'b0, n} + (CW+1)'(3);
    return {1'b0, t[CW:2]};
  endfunction

  function automatic logic [2:0] last_group_lanes(input logic [CW-1:0] n);
    return (n[1:0] == 2'b00) ? 3'd4 : {1'b0, n[1:0]};
  endfunction

endpackage

// File: rtl/pool_group_fifo.sv
// Two-slot ping-pong buffer holding one four-lane pooling group per slot.
// The full flag is registered from the next occupancy so it is glitch-free.
module pool_group_fifo
  import pool_pkg::*;
(
  input  logic            clk,
  input  logic            rst_fsm,
  input  logic            flush,
  input  logic            wr_en,
  input  logic [4*DW-1:0] wr_data,
  input  logic            rd_en,
  output logic [4*DW-1:0] rd_data,
  output logic            full,
  output logic            empty
);

  logic [4*DW-1:0] slot_q [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count;
  logic [1:0]      count_next;
  logic            full_q;
  logic            do_wr;
  logic            do_rd;

  assign do_wr = wr_en && !full_q;
  assign do_rd = rd_en && (count != 2'd0);

  always_comb begin
    count_next = count;
    case ({do_wr, do_rd})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_fsm || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      full_q <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= ~wr_ptr;
      if (do_rd) rd_ptr <= ~rd_ptr;
      count  <= count_next;
      full_q <= (count_next == 2'd2);
    end
  end

  // Slot payload needs no reset: it is only observed while the slot is occupied.
  always_ff @(posedge clk) begin
    if (do_wr) slot_q[wr_ptr] <= wr_data;
  end

  assign rd_data = slot_q[rd_ptr];
  assign full    = full_q;
  assign empty   = (count == 2'd0);

endmodule

// File: rtl/pool_result_serializer.sv
// Serialises the four parallel pooling results into one valid/ready word
// stream, tracking frame length, last word and sticky overflow.
module pool_result_serializer
  import pool_pkg::*;
(
  input  logic          clk,
  input  logic          rst_fsm,
  input  logic          start,
  input  logic [4:0]    size_1,
  input  logic [4:0]    size_2,
  input  logic          pool_sel,
  input  logic          en,
  input  logic [DW-1:0] o_pool_1,
  input  logic [DW-1:0] o_pool_2,
  input  logic [DW-1:0] o_pool_3,
  input  logic [DW-1:0] o_pool_4,
  output logic          stall,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic [CW-1:0] m_idx,
  output logic          busy,
  output logic          done,
  output logic          overflow
);

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   words_calc;
  logic [CW-1:0]   n_words;
  logic [CW-1:0]   n_groups;
  logic [2:0]      last_lanes;
  logic [CW-1:0]   groups_in;
  logic [CW-1:0]   groups_out;
  logic [1:0]      lane_idx;
  logic [2:0]      lanes_cur;
  logic            start_ok;
  logic            capture;
  logic            xfer;
  logic            lane_end;
  logic            last_group;
  logic [4*DW-1:0] head;
  logic            fifo_full;
  logic            fifo_empty;

  assign words_calc = frame_words(size_1, size_2, pool_sel);
  assign start_ok   = (state == IDLE) && start;
  assign capture    = en && !fifo_full && (state == RUN) && (groups_in < n_groups);
  assign m_valid    = (state == RUN) && !fifo_empty;
  assign xfer       = m_valid && m_ready;
  assign last_group = (groups_out == n_groups - CW'(1));
  assign lanes_cur  = last_group ? last_lanes : 3'd4;
  assign lane_end   = ({1'b0, lane_idx} == lanes_cur - 3'd1);
  assign m_last     = m_valid && (m_idx == n_words - CW'(1));
  assign stall      = fifo_full;
  assign busy       = (state == RUN);
  assign done       = (state == FIN);

  pool_group_fifo u_fifo (
    .clk     (clk),
    .rst_fsm (rst_fsm),
    .flush   (start_ok),
    .wr_en   (capture),
    .wr_data ({o_pool_4, o_pool_3, o_pool_2, o_pool_1}),
    .rd_en   (xfer && lane_end),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst_fsm) state <= IDLE;
    else         state <= state_next;
  end

  // An empty frame skips RUN so done still pulses exactly once.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (words_calc == '0) ? FIN : RUN;
      RUN:  if (xfer && m_last) state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_fsm) begin
      n_words    <= '0;
      n_groups   <= '0;
      last_lanes <= 3'd0;
      groups_in  <= '0;
      groups_out <= '0;
      lane_idx   <= 2'd0;
      m_idx      <= '0;
      overflow   <= 1'b0;
    end else if (start_ok) begin
      n_words    <= words_calc;
      n_groups   <= frame_groups(words_calc);
      last_lanes <= last_group_lanes(words_calc);
      groups_in  <= '0;
      groups_out <= '0;
      lane_idx   <= 2'd0;
      m_idx      <= '0;
      overflow   <= 1'b0;
    end else begin
      if (capture) groups_in <= groups_in + CW'(1);
      if (en && !capture) overflow <= 1'b1;
      if (xfer) begin
        m_idx <= m_idx + CW'(1);
        if (lane_end) begin
          lane_idx   <= 2'd0;
          groups_out <= groups_out + CW'(1);
        end else begin
          lane_idx <= lane_idx + 2'd1;
        end
      end
    end
  end

  always_comb begin
    m_data = '0;
    if (m_valid) begin
      case (lane_idx)
        2'd0:    m_data = head[0*DW +: DW];
        2'd1:    m_data = head[1*DW +: DW];
        2'd2:    m_data = head[2*DW +: DW];
        default: m_data = head[3*DW +: DW];
      endcase
    end
  end

endmodule

// File: tb/tb_pool_result_serializer.sv
// Self-checking bench for pool_result_serializer: table of frames plus
// random frames, checked against a word-queue reference model.
module tb_pool_result_serializer;
  import pool_pkg::*;

  logic          clk = 1'b0;
  logic          rst_fsm;
  logic          start;
  logic [4:0]    size_1;
  logic [4:0]    size_2;
  logic          pool_sel;
  logic          en;
  logic [DW-1:0] o_pool_1;
  logic [DW-1:0] o_pool_2;
  logic [DW-1:0] o_pool_3;
  logic [DW-1:0] o_pool_4;
  logic          stall;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic [CW-1:0] m_idx;
  logic          busy;
  logic          done;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0] s1;
    logic [4:0] s2;
    logic       sel;
    int         n;
    int         ready_mode;
    bit         seq_data;
    bit         do_drop;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  pool_result_serializer dut (
    .clk      (clk),
    .rst_fsm  (rst_fsm),
    .start    (start),
    .size_1   (size_1),
    .size_2   (size_2),
    .pool_sel (pool_sel),
    .en       (en),
    .o_pool_1 (o_pool_1),
    .o_pool_2 (o_pool_2),
    .o_pool_3 (o_pool_3),
    .o_pool_4 (o_pool_4),
    .stall    (stall),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .m_idx    (m_idx),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic e, input logic rdy);
    start   = st;
    en      = e;
    m_ready = rdy;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_stall"}, stall, 0);
    checkOutput({tag, "_m_valid"}, m_valid, 0);
    checkOutput({tag, "_m_data"}, m_data, 0);
    checkOutput({tag, "_m_last"}, m_last, 0);
    checkOutput({tag, "_m_idx"}, m_idx, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_overflow"}, overflow, 0);
  endtask

  // Reference: the stream is the first n lanes of the accepted groups in order;
  // buffered groups = accepted - fully transferred groups, capacity two.
  task automatic run_frame(input logic [4:0] s1, input logic [4:0] s2, input logic sel,
                           input int n, input int ready_mode, input bit seq_data,
                           input bit do_drop, input int abort_words);
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] lane_v [4];
    logic [DW-1:0] prev_data;
    logic [CW-1:0] prev_idx;
    logic          rdy_v;
    logic          en_v;
    int            groups, accepted, words_out, drained, cyc;
    bit            exp_ovf, dropped, prev_hold, is_last, finished;

    groups    = (n + 3) / 4;
    accepted  = 0;
    words_out = 0;
    cyc       = 0;
    exp_ovf   = 0;
    dropped   = 0;
    prev_hold = 0;
    finished  = 0;
    prev_data = '0;
    prev_idx  = '0;

    size_1   = s1;
    size_2   = s2;
    pool_sel = sel;
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("busy_after_start", busy, n != 0);
    checkOutput("done_after_start", done, n == 0);
    checkOutput("overflow_after_start", overflow, 0);
    if (n == 0) begin
      checkOutput("zero_no_valid", m_valid, 0);
      tick();
      checkOutput("zero_done_clear", done, 0);
      checkOutput("zero_busy", busy, 0);
      checkOutput("zero_no_valid2", m_valid, 0);
      return;
    end

    while (!finished) begin
      drained = (words_out == n) ? groups : words_out / 4;
      checkOutput("stall", stall, (accepted - drained) == 2);
      checkOutput("m_valid", m_valid, accepted > drained);
      checkOutput("overflow", overflow, exp_ovf);
      checkOutput("busy", busy, 1);
      if (prev_hold) begin
        checkOutput("hold_data", m_data, prev_data);
        checkOutput("hold_idx", m_idx, prev_idx);
      end
      if (m_valid && words_out < exp_q.size()) begin
        checkOutput("m_data", m_data, exp_q[words_out]);
        checkOutput("m_idx", m_idx, words_out);
        checkOutput("m_last", m_last, words_out == n - 1);
      end

      case (ready_mode)
        0:       rdy_v = 1'b1;
        1:       rdy_v = (cyc % 2 == 0);
        default: rdy_v = 1'($urandom_range(0, 1));
      endcase
      en_v = 1'b0;
      if (!stall && accepted < groups && (ready_mode != 2 || $urandom_range(0, 2) != 0)) begin
        en_v = 1'b1;
        for (int i = 0; i < 4; i++) begin
          lane_v[i] = seq_data ? DW'(accepted * 4 + i + 1) : DW'($urandom);
          if (exp_q.size() < n) exp_q.push_back(lane_v[i]);
        end
        accepted++;
      end else if (do_drop && !dropped && stall) begin
        en_v = 1'b1;
        for (int i = 0; i < 4; i++) lane_v[i] = 16'hDEAD;
        dropped = 1;
        exp_ovf = 1;
      end else begin
        for (int i = 0; i < 4; i++) lane_v[i] = '0;
      end
      o_pool_1 = lane_v[0];
      o_pool_2 = lane_v[1];
      o_pool_3 = lane_v[2];
      o_pool_4 = lane_v[3];
      applyStimulus(1'b0, en_v, rdy_v);

      prev_hold = m_valid && !rdy_v;
      prev_data = m_data;
      prev_idx  = m_idx;
      is_last   = m_valid && rdy_v && (words_out == n - 1);
      if (m_valid && rdy_v) words_out++;
      tick();
      cyc++;
      if (is_last) finished = 1;
      if (words_out == abort_words) return;
      if (cyc > 3000) begin
        checks++;
        errors++;
        $display("[TB] FAIL frame_timeout: got %0d words expected %0d", words_out, n);
        applyStimulus(1'b0, 1'b0, 1'b0);
        return;
      end
    end

    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("done_pulse", done, 1);
    checkOutput("fin_busy", busy, 0);
    checkOutput("fin_valid", m_valid, 0);
    checkOutput("fin_overflow", overflow, exp_ovf);
    tick();
    checkOutput("done_clear", done, 0);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_overflow", overflow, exp_ovf);
  endtask

  initial begin
    rst_fsm  = 1'b1;
    size_1   = '0;
    size_2   = '0;
    pool_sel = 1'b0;
    o_pool_1 = '0;
    o_pool_2 = '0;
    o_pool_3 = '0;
    o_pool_4 = '0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check_all_zero("reset");
    rst_fsm = 1'b0;

    vecs[0] = '{5'd4,  5'd4,  1'b0, 4,   0, 1'b1, 1'b0};
    vecs[1] = '{5'd6,  5'd6,  1'b0, 9,   0, 1'b1, 1'b0};
    vecs[2] = '{5'd16, 5'd16, 1'b0, 64,  1, 1'b0, 1'b0};
    vecs[3] = '{5'd16, 5'd16, 1'b0, 64,  1, 1'b0, 1'b1};
    vecs[4] = '{5'd3,  5'd9,  1'b1, 0,   0, 1'b0, 1'b0};
    vecs[5] = '{5'd31, 5'd31, 1'b0, 225, 2, 1'b0, 1'b0};
    vecs[6] = '{5'd5,  5'd7,  1'b1, 1,   2, 1'b0, 1'b0};
    vecs[7] = '{5'd10, 5'd3,  1'b0, 5,   0, 1'b1, 1'b0};
    vecs[8] = '{5'd31, 5'd31, 1'b1, 49,  1, 1'b0, 1'b0};
    vecs[9] = '{5'd8,  5'd8,  1'b1, 4,   0, 1'b1, 1'b0};

    for (int v = 0; v < NV; v++) begin
      run_frame(vecs[v].s1, vecs[v].s2, vecs[v].sel, vecs[v].n, vecs[v].ready_mode,
                vecs[v].seq_data, vecs[v].do_drop, -1);
    end

    // A result arriving with no frame open is dropped and flagged.
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("idle_en_overflow", overflow, 1);
    checkOutput("idle_en_no_valid", m_valid, 0);

    // Reset after 5 of 16 words, then a fresh 4-word frame.
    run_frame(5'd8, 5'd8, 1'b0, 16, 0, 1'b1, 1'b0, 5);
    rst_fsm = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    check_all_zero("midreset");
    rst_fsm = 1'b0;
    run_frame(5'd8, 5'd8, 1'b1, 4, 2, 1'b0, 1'b0, -1);

    for (int r = 0; r < 6; r++) begin
      logic [4:0] s1;
      logic [4:0] s2;
      logic       sel;
      int         k;
      s1  = 5'($urandom_range(0, 31));
      s2  = 5'($urandom_range(0, 31));
      sel = 1'($urandom_range(0, 1));
      k   = sel ? 2 : 1;
      run_frame(s1, s2, sel, (int'(s1) >> k) * (int'(s2) >> k), 2, 1'b0,
                1'($urandom_range(0, 1)), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
